// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader.
//   state_e        : loader FSM states
//   LEN_BYTES      : number of little-endian bytes in the word-count header
//   CNT_W          : width of the word count and word index
//   bytes_per_word : bytes needed to assemble one instruction word
package loader_pkg;

  localparam int unsigned LEN_BYTES = 2;
  localparam int unsigned CNT_W     = LEN_BYTES * 8;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StCollect,
    StWrite,
    StDone
  } state_e;

  function automatic int unsigned bytes_per_word(int unsigned instr_len);
    return instr_len / 8;
  endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Assembles a little-endian instruction word from a byte stream.
// The first byte loaded after a clear ends up in bits 7:0.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear_i    : drop any partial word and restart at byte 0
//   load_i     : shift byte_i into the word
//   byte_i     : incoming byte
//   word_o     : registered assembled word
//   last_o     : the next load completes the word
module loader_word_assembler
  import loader_pkg::*;
#(
  parameter int unsigned InstrLen = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_i,
  input  logic                load_i,
  input  logic [7:0]          byte_i,
  output logic [InstrLen-1:0] word_o,
  output logic                last_o
);

  localparam int unsigned Bpw  = bytes_per_word(InstrLen);
  localparam int unsigned IdxW = (Bpw > 1) ? $clog2(Bpw) : 1;

  logic [IdxW-1:0]     idx_q, idx_d;
  logic [InstrLen-1:0] word_q, word_d;

  assign last_o = (idx_q == IdxW'(Bpw - 1));
  assign word_o = word_q;

  // Bytes enter at the top and shift down, so after Bpw loads the first byte sits in 7:0.
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear_i) begin
      idx_d  = '0;
      word_d = '0;
    end else if (load_i) begin
      word_d = (word_q >> 8) | (InstrLen'(byte_i) << (InstrLen - 8));
      idx_d  = last_o ? '0 : idx_q + IdxW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Streams a length-prefixed program image into instruction memory through a debug
// write port while holding the CPU fetch pipeline in reset.
// Stream format: 16-bit little-endian word count N, then N little-endian words.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start, abort         : load request (IDLE/DONE only), terminate in-progress load
//   base_addr            : word address of the first instruction, captured on start
//   byte_valid/data/ready: byte stream handshake
//   dbg_wr_en/addr/instr : one-cycle instruction-memory write
//   cpu_hold, busy       : load in progress
//   done, err            : sticky completion / abort flags, cleared by the next start
module instruction_loader
  import loader_pkg::*;
#(
  parameter int unsigned XLEN               = 64,
  parameter int unsigned INSTRUCTION_LENGTH = XLEN / 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [XLEN-1:0]               base_addr,
  input  logic                          byte_valid,
  input  logic [7:0]                    byte_data,
  output logic                          byte_ready,
  output logic                          dbg_wr_en,
  output logic [XLEN-1:0]               dbg_addr,
  output logic [INSTRUCTION_LENGTH-1:0] dbg_instr,
  output logic                          cpu_hold,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   base_q, base_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  widx_q, widx_d;
  logic [CNT_W-1:0]  widx_inc;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              busy_st;
  logic              rx_st;
  logic              accept;
  logic              asm_clear;
  logic              asm_load;
  logic              asm_last;

  assign busy_st = (state_q == StLenLo) || (state_q == StLenHi) ||
                   (state_q == StCollect) || (state_q == StWrite);
  assign rx_st   = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StCollect);

  // Abort takes priority: the byte is neither accepted nor signalled ready, and a write
  // in progress is squashed.
  assign byte_ready = rx_st & ~abort;
  assign accept     = byte_valid & byte_ready;
  assign dbg_wr_en  = (state_q == StWrite) & ~abort;
  assign dbg_addr   = addr_q;
  assign cpu_hold   = busy_st;
  assign busy       = busy_st;
  assign done       = done_q;
  assign err        = err_q;
  assign widx_inc   = widx_q + CNT_W'(1);

  loader_word_assembler #(
    .InstrLen (INSTRUCTION_LENGTH)
  ) u_asm (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (asm_clear),
    .load_i  (asm_load),
    .byte_i  (byte_data),
    .word_o  (dbg_instr),
    .last_o  (asm_last)
  );

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    widx_d    = widx_q;
    done_d    = done_q;
    err_d     = err_q;
    asm_clear = 1'b0;
    asm_load  = 1'b0;

    if (busy_st && abort) begin
      state_d = StIdle;
      err_d   = 1'b1;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d   = StLenLo;
            base_d    = base_addr;
            widx_d    = '0;
            done_d    = 1'b0;
            err_d     = 1'b0;
            asm_clear = 1'b1;
          end
        end
        StLenLo: begin
          if (accept) begin
            cnt_d   = {cnt_q[15:8], byte_data};
            state_d = StLenHi;
          end
        end
        StLenHi: begin
          if (accept) begin
            cnt_d = {byte_data, cnt_q[7:0]};
            if ({byte_data, cnt_q[7:0]} == '0) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              state_d = StCollect;
            end
          end
        end
        StCollect: begin
          if (accept) begin
            asm_load = 1'b1;
            if (asm_last) begin
              state_d = StWrite;
              // Address is latched here so the write port is driven purely from flops.
              addr_d  = base_q + XLEN'(widx_q);
            end
          end
        end
        StWrite: begin
          widx_d = widx_inc;
          if (widx_inc == cnt_q) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StCollect;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      base_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      widx_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader (XLEN=64, 32-bit instructions).
// A reference model turns (base, word list) into a byte stream and an expected
// write list; every observed write is checked against the head of that list.
module tb_instruction_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [63:0] base_addr;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        dbg_wr_en;
  logic [63:0] dbg_addr;
  logic [31:0] dbg_instr;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  instruction_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .dbg_wr_en  (dbg_wr_en),
    .dbg_addr   (dbg_addr),
    .dbg_instr  (dbg_instr),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  typedef struct packed {
    logic [63:0] a;
    logic [31:0] d;
  } wr_t;

  int          tests = 0;
  int          fails = 0;
  wr_t         exp_q[$];
  logic [7:0]  stream[$];
  logic        acc;
  int          busy_cnt;
  int          wr_cnt = 0;
  logic [63:0] last_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge (inputs already applied), then pass the rising edge.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    acc = byte_valid && byte_ready;
    if (busy) busy_cnt++;
    if (dbg_wr_en) begin
      wr_cnt++;
      last_addr = dbg_addr;
      check("ready_low_in_write", byte_ready, 0);
      check("write_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", dbg_addr, e.a);
        check("wr_data", dbg_instr, e.d);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Model: word count header then each word little-endian; writes land at base+i mod 2^64.
  task automatic build(input logic [63:0] base, input int n);
    logic [31:0] w;
    wr_t         e;
    stream.delete();
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      for (int b = 0; b < 4; b++) stream.push_back(8'(w >> (8 * b)));
      e.a = base + 64'(i);
      e.d = w;
      exp_q.push_back(e);
    end
  endtask

  task automatic start_load(input logic [63:0] base);
    start     = 1'b1;
    base_addr = base;
    tick();
    start     = 1'b0;
    base_addr = ~base;
    busy_cnt  = 0;
  endtask

  // mode 0: valid held high, 1: alternating, 2: random. poke: byte index at which a
  // start with a bogus base is pulsed mid-load (-1 for none).
  task automatic send(input logic [7:0] q[$], input int len, input int mode, input int poke);
    int i     = 0;
    int guard = 0;
    bit ph    = 1'b0;
    bit poked = 1'b0;
    while (i < len && guard < 4000) begin
      if (mode == 0) byte_valid = 1'b1;
      else if (mode == 1) byte_valid = ph;
      else byte_valid = 1'($urandom);
      ph        = ~ph;
      byte_data = byte_valid ? q[i] : 8'($urandom);
      if (i == poke && !poked) begin
        start     = 1'b1;
        base_addr = {$urandom, $urandom};
        poked     = 1'b1;
      end
      tick();
      start = 1'b0;
      if (acc) i++;
      guard++;
    end
    byte_valid = 1'b0;
    check("send_complete", 64'(i), 64'(len));
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy === 1'b1 && g < 200) begin
      tick();
      g++;
    end
    check("idle_timeout", g < 200, 1);
  endtask

  initial begin
    int          w0;
    int          n;
    logic [63:0] base;
    wr_t         e;

    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    base_addr  = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    #1;
    check("rst_ready", byte_ready, 0);
    check("rst_wr_en", dbg_wr_en, 0);
    check("rst_addr", dbg_addr, 0);
    check("rst_instr", dbg_instr, 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // Two-word directed image from literal bytes.
    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    e.a = 64'h100; e.d = 32'h0000_0013; exp_q.push_back(e);
    e.a = 64'h101; e.d = 32'h0010_0093; exp_q.push_back(e);
    w0 = wr_cnt;
    start_load(64'h100);
    check("hold_after_start", cpu_hold, 1);
    send(stream, stream.size(), 0, -1);
    wait_idle();
    check("dir_writes", 64'(wr_cnt - w0), 2);
    check("dir_done", done, 1);
    check("dir_hold_off", cpu_hold, 0);
    check("dir_throughput", 64'(busy_cnt), 12);

    // Zero-length image.
    w0 = wr_cnt;
    start_load(64'h200);
    check("n0_done_cleared", done, 0);
    stream = '{8'h00, 8'h00};
    send(stream, 2, 0, -1);
    check("n0_done", done, 1);
    check("n0_busy", busy, 0);
    check("n0_cycles", 64'(busy_cnt), 2);
    check("n0_no_write", 64'(wr_cnt - w0), 0);

    // Abort in DONE is ignored; start+abort in DONE starts a load.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_done_ignored_done", done, 1);
    check("abort_done_ignored_err", err, 0);
    start = 1'b1; abort = 1'b1; base_addr = 64'h5;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_wins_busy", busy, 1);
    check("start_wins_err", err, 0);
    check("start_wins_done", done, 0);
    send(stream, 2, 0, -1);
    check("start_wins_finish", done, 1);

    // One word with byte_valid toggling.
    w0 = wr_cnt;
    build(64'h2000, 1);
    start_load(64'h2000);
    send(stream, stream.size(), 1, -1);
    wait_idle();
    check("toggle_writes", 64'(wr_cnt - w0), 1);
    check("toggle_done", done, 1);

    // Address wraps past 2^64-1.
    build(64'hFFFF_FFFF_FFFF_FFFF, 2);
    start_load(64'hFFFF_FFFF_FFFF_FFFF);
    send(stream, stream.size(), 0, -1);
    wait_idle();
    check("wrap_addr", last_addr, 64'h0);
    check("wrap_err", err, 0);

    // Start mid-load is ignored: base stays 0x40.
    build(64'h40, 1);
    start_load(64'h40);
    send(stream, stream.size(), 0, 3);
    wait_idle();
    check("busy_start_pending", 64'(exp_q.size()), 0);
    check("busy_start_done", done, 1);

    // Abort after two bytes of the first word.
    w0 = wr_cnt;
    build(64'h500, 1);
    exp_q.delete();
    start_load(64'h500);
    send(stream, 4, 0, -1);
    byte_valid = 1'b1; byte_data = 8'hAA; abort = 1'b1;
    tick();
    abort = 1'b0; byte_valid = 1'b0;
    check("abort_no_accept", acc, 0);
    check("abort_busy", busy, 0);
    check("abort_err", err, 1);
    check("abort_done", done, 0);
    check("abort_no_write", 64'(wr_cnt - w0), 0);
    start_load(64'h600);
    check("restart_err_clear", err, 0);
    check("restart_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_lenlo_err", err, 1);

    // Abort during the WRITE cycle squashes the write.
    w0 = wr_cnt;
    build(64'h700, 1);
    exp_q.delete();
    start_load(64'h700);
    send(stream, stream.size(), 0, -1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_write_none", 64'(wr_cnt - w0), 0);
    check("abort_write_err", err, 1);
    check("abort_write_idle", busy, 0);

    // Asynchronous reset mid-collect.
    w0 = wr_cnt;
    build(64'h300, 2);
    exp_q.delete();
    start_load(64'h300);
    send(stream, 3, 0, -1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", byte_ready, 0);
    check("arst_wr_en", dbg_wr_en, 0);
    check("arst_addr", dbg_addr, 0);
    check("arst_instr", dbg_instr, 0);
    check("arst_hold", cpu_hold, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_resume_idle", busy, 0);
    check("arst_no_write", 64'(wr_cnt - w0), 0);

    // Randomized loads.
    for (int r = 0; r < 6; r++) begin
      n    = int'($urandom_range(1, 5));
      base = (r == 0) ? 64'hFFFF_FFFF_FFFF_FFFE : {$urandom, $urandom};
      w0   = wr_cnt;
      build(base, n);
      start_load(base);
      send(stream, stream.size(), r % 3, (r == 4) ? 2 : -1);
      wait_idle();
      check("rnd_writes", 64'(wr_cnt - w0), 64'(n));
      check("rnd_pending", 64'(exp_q.size()), 0);
      check("rnd_done", done, 1);
      check("rnd_err", err, 0);
      if (r % 3 == 0) check("rnd_throughput", 64'(busy_cnt), 64'(2 + 5 * n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
